// File: rtl/spio_spinnaker_link_pkt_arbiter.sv
// Four-input round-robin packet arbiter feeding a single-entry output register slice.
// Also reports the source port of the held packet and counts packets delivered downstream.
module spio_spinnaker_link_pkt_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PKT_BITS  = 72
) (
    input  logic                          CLK_IN,
    input  logic                          RESET_IN,
    input  logic [NUM_PORTS*PKT_BITS-1:0] PKT_DATA_IN,
    input  logic [NUM_PORTS-1:0]          PKT_VLD_IN,
    output logic [NUM_PORTS-1:0]          PKT_RDY_OUT,
    input  logic [NUM_PORTS-1:0]          PORT_EN_IN,
    output logic [PKT_BITS-1:0]           PKT_DATA_OUT,
    output logic                          PKT_VLD_OUT,
    input  logic                          PKT_RDY_IN,
    output logic [1:0]                    PKT_SRC_OUT,
    output logic [31:0]                   PKT_CNT_OUT,
    input  logic                          CNT_CLR_IN
);

    logic [NUM_PORTS-1:0] req_s;
    logic [NUM_PORTS-1:0] gnt_s;
    logic [1:0]           gnt_idx_s;
    logic [1:0]           cand_s;
    logic                 gnt_any_s;
    logic                 load_s;
    logic                 in_hs_s;
    logic                 out_hs_s;

    logic                 vld_q;
    logic                 vld_d;
    logic [PKT_BITS-1:0]  data_q;
    logic [PKT_BITS-1:0]  data_d;
    logic [1:0]           src_q;
    logic [1:0]           src_d;
    logic [1:0]           ptr_q;
    logic [1:0]           ptr_d;
    logic [31:0]          pkt_cnt_q;
    logic [31:0]          pkt_cnt_d;

    assign req_s    = PKT_VLD_IN & PORT_EN_IN;
    // The slot is free when empty or when the held packet leaves this cycle.
    assign load_s   = (~vld_q) | PKT_RDY_IN;
    assign in_hs_s  = gnt_any_s & load_s;
    assign out_hs_s = vld_q & PKT_RDY_IN;

    // Round-robin search starting at the priority pointer.
    always_comb begin
        gnt_s     = '0;
        gnt_idx_s = ptr_q;
        gnt_any_s = 1'b0;
        cand_s    = ptr_q;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand_s = ptr_q + 2'(k);
            if (!gnt_any_s && req_s[cand_s]) begin
                gnt_any_s = 1'b1;
                gnt_idx_s = cand_s;
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
        if (gnt_any_s) begin
            gnt_s[gnt_idx_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
    end

    // Ready is held low during reset even though the grant logic is live.
    assign PKT_RDY_OUT = RESET_IN ? {NUM_PORTS{1'b0}}
                                  : (load_s ? gnt_s : {NUM_PORTS{1'b0}});

    // Output slice and pointer next state.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        src_d  = src_q;
        ptr_d  = ptr_q;
        if (in_hs_s) begin
            vld_d  = 1'b1;
            data_d = PKT_DATA_IN[gnt_idx_s*PKT_BITS +: PKT_BITS];
            src_d  = gnt_idx_s;
            ptr_d  = gnt_idx_s + 2'd1;
        end else if (load_s) begin
            vld_d  = 1'b0;
        end else begin
            vld_d  = vld_q;
        end
    end

    // Delivered-packet counter; clear wins over a simultaneous increment.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (CNT_CLR_IN) begin
            pkt_cnt_d = 32'd0;
        end else if (out_hs_s) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            vld_q     <= 1'b0;
            data_q    <= {PKT_BITS{1'b0}};
            src_q     <= 2'd0;
            ptr_q     <= 2'd0;
            pkt_cnt_q <= 32'd0;
        end else begin
            vld_q     <= vld_d;
            data_q    <= data_d;
            src_q     <= src_d;
            ptr_q     <= ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign PKT_VLD_OUT  = vld_q;
    assign PKT_DATA_OUT = data_q;
    assign PKT_SRC_OUT  = src_q;
    assign PKT_CNT_OUT  = pkt_cnt_q;

endmodule

// File: tb/tb_spio_spinnaker_link_pkt_arbiter.sv
// Directed bench for the four-port round-robin packet arbiter.
module tb_spio_spinnaker_link_pkt_arbiter;

    logic         clk;
    logic         rst;
    logic [287:0] pkt_data_in;
    logic [3:0]   pkt_vld_in;
    logic [3:0]   pkt_rdy_out;
    logic [3:0]   port_en_in;
    logic [71:0]  pkt_data_out;
    logic         pkt_vld_out;
    logic         pkt_rdy_in;
    logic [1:0]   pkt_src_out;
    logic [31:0]  pkt_cnt_out;
    logic         cnt_clr_in;

    int errors;
    int checks;

    spio_spinnaker_link_pkt_arbiter dut (
        .CLK_IN       (clk),
        .RESET_IN     (rst),
        .PKT_DATA_IN  (pkt_data_in),
        .PKT_VLD_IN   (pkt_vld_in),
        .PKT_RDY_OUT  (pkt_rdy_out),
        .PORT_EN_IN   (port_en_in),
        .PKT_DATA_OUT (pkt_data_out),
        .PKT_VLD_OUT  (pkt_vld_out),
        .PKT_RDY_IN   (pkt_rdy_in),
        .PKT_SRC_OUT  (pkt_src_out),
        .PKT_CNT_OUT  (pkt_cnt_out),
        .CNT_CLR_IN   (cnt_clr_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [71:0] make_pkt(input int p, input logic [31:0] key);
        logic [31:0] payload;
        logic [7:0]  hdr;
        payload = 32'hC0DE_0000 | 32'(p);
        hdr     = 8'h40 | 8'(p);
        return {payload, key, hdr};
    endfunction

    task automatic put(input int p, input logic [31:0] key);
        pkt_data_in[72*p +: 72] = make_pkt(p, key);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pkt_vld_in = 4'b1111; port_en_in = 4'b1111; pkt_rdy_in = 1'b1;
        cnt_clr_in = 1'b0;
        for (int p = 0; p < 4; p++) put(p, 32'hAA00 + 32'(p));
        #2;
        checks++; if (pkt_rdy_out !== 4'b0000) begin errors++; $display("FAIL reset_rdy: got %b exp 0000", pkt_rdy_out); end
        checks++; if (pkt_vld_out !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b exp 0", pkt_vld_out); end
        checks++; if (pkt_data_out !== 72'd0) begin errors++; $display("FAIL reset_data: got %h exp 0", pkt_data_out); end
        checks++; if (pkt_src_out !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d exp 0", pkt_src_out); end
        checks++; if (pkt_cnt_out !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %h exp 0", pkt_cnt_out); end
        tick();
        pkt_vld_in = 4'b0000;
        rst = 1'b0;
    endtask

    task automatic test_single_port();
        pkt_vld_in = 4'b0100; put(2, 32'h0000_0001); pkt_rdy_in = 1'b1;
        #1;
        checks++; if (pkt_rdy_out !== 4'b0100) begin errors++; $display("FAIL single_rdy: got %b exp 0100", pkt_rdy_out); end
        tick();
        pkt_vld_in = 4'b0000;
        #1;
        checks++; if (pkt_rdy_out !== 4'b0000) begin errors++; $display("FAIL single_rdy_drop: got %b exp 0000", pkt_rdy_out); end
        checks++; if (pkt_vld_out !== 1'b1) begin errors++; $display("FAIL single_vld: got %b exp 1", pkt_vld_out); end
        checks++; if (pkt_data_out[39:8] !== 32'h0000_0001) begin errors++; $display("FAIL single_key: got %h exp 00000001", pkt_data_out[39:8]); end
        checks++; if (pkt_data_out !== make_pkt(2, 32'h1)) begin errors++; $display("FAIL single_data: got %h exp %h", pkt_data_out, make_pkt(2, 32'h1)); end
        checks++; if (pkt_src_out !== 2'd2) begin errors++; $display("FAIL single_src: got %0d exp 2", pkt_src_out); end
        tick();
        checks++; if (pkt_vld_out !== 1'b0) begin errors++; $display("FAIL single_drain_vld: got %b exp 0", pkt_vld_out); end
        checks++; if (pkt_cnt_out !== 32'd1) begin errors++; $display("FAIL single_cnt: got %0d exp 1", pkt_cnt_out); end
    endtask

    task automatic test_fairness();
        rst = 1'b1;
        #2;
        tick();
        rst = 1'b0;
        for (int p = 0; p < 4; p++) put(p, 32'h10 + 32'(p));
        pkt_vld_in = 4'b1111; pkt_rdy_in = 1'b1;
        #1;
        checks++; if (pkt_rdy_out !== 4'b0001) begin errors++; $display("FAIL fair_first_rdy: got %b exp 0001", pkt_rdy_out); end
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++; if (pkt_vld_out !== 1'b1) begin errors++; $display("FAIL fair_vld[%0d]: got %b exp 1", c, pkt_vld_out); end
            checks++; if (pkt_src_out !== 2'(c % 4)) begin errors++; $display("FAIL fair_src[%0d]: got %0d exp %0d", c, pkt_src_out, c % 4); end
            checks++; if (pkt_data_out !== make_pkt(c % 4, 32'h10 + 32'(c % 4))) begin errors++; $display("FAIL fair_data[%0d]: got %h", c, pkt_data_out); end
        end
        pkt_vld_in = 4'b0000;
        tick();
        checks++; if (pkt_cnt_out !== 32'd8) begin errors++; $display("FAIL fair_cnt: got %0d exp 8", pkt_cnt_out); end
        checks++; if (pkt_vld_out !== 1'b0) begin errors++; $display("FAIL fair_drain: got %b exp 0", pkt_vld_out); end
    endtask

    task automatic test_backpressure();
        put(1, 32'hB1B1_0001); pkt_vld_in = 4'b0010; pkt_rdy_in = 1'b0;
        tick();
        put(1, 32'hB1B1_0002); put(0, 32'hB0); put(2, 32'hB2); put(3, 32'hB3);
        pkt_vld_in = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (pkt_rdy_out !== 4'b0000) begin errors++; $display("FAIL bp_rdy[%0d]: got %b exp 0000", c, pkt_rdy_out); end
            checks++; if (pkt_src_out !== 2'd1 || pkt_vld_out !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got src %0d vld %b exp src 1 vld 1", c, pkt_src_out, pkt_vld_out); end
            checks++; if (pkt_data_out !== make_pkt(1, 32'hB1B1_0001)) begin errors++; $display("FAIL bp_data[%0d]: got %h exp %h", c, pkt_data_out, make_pkt(1, 32'hB1B1_0001)); end
            tick();
        end
        pkt_rdy_in = 1'b1;
        #1;
        checks++; if (pkt_rdy_out !== 4'b0100) begin errors++; $display("FAIL bp_release_rdy: got %b exp 0100", pkt_rdy_out); end
        tick();
        pkt_vld_in = 4'b0000;
        checks++; if (pkt_src_out !== 2'd2 || pkt_data_out !== make_pkt(2, 32'hB2)) begin errors++; $display("FAIL bp_next: got src %0d data %h exp src 2", pkt_src_out, pkt_data_out); end
        tick();
        checks++; if (pkt_cnt_out !== 32'd10) begin errors++; $display("FAIL bp_cnt: got %0d exp 10", pkt_cnt_out); end
    endtask

    task automatic test_enable_mask();
        int exp;
        port_en_in = 4'b1010; pkt_vld_in = 4'b1111; pkt_rdy_in = 1'b1;
        for (int p = 0; p < 4; p++) put(p, 32'hE0 + 32'(p));
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 0) ? 3 : 1;
            #1;
            checks++; if (pkt_rdy_out !== (4'b0001 << exp)) begin errors++; $display("FAIL en_rdy[%0d]: got %b exp %b", i, pkt_rdy_out, 4'b0001 << exp); end
            tick();
            checks++; if (pkt_src_out !== 2'(exp) || pkt_data_out !== make_pkt(exp, 32'hE0 + 32'(exp))) begin errors++; $display("FAIL en_src[%0d]: got %0d exp %0d", i, pkt_src_out, exp); end
        end
        pkt_vld_in = 4'b0000; port_en_in = 4'b1111;
        tick();
        checks++; if (pkt_cnt_out !== 32'd14 || pkt_vld_out !== 1'b0) begin errors++; $display("FAIL en_cnt: got %0d vld %b exp 14 vld 0", pkt_cnt_out, pkt_vld_out); end
    endtask

    task automatic test_counter_edges();
        force dut.pkt_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_cnt_q;
        #1;
        checks++; if (pkt_cnt_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cnt_preload: got %h exp ffffffff", pkt_cnt_out); end
        put(0, 32'hC0); pkt_vld_in = 4'b0001; pkt_rdy_in = 1'b1;
        tick();
        pkt_vld_in = 4'b0000;
        tick();
        checks++; if (pkt_cnt_out !== 32'd0) begin errors++; $display("FAIL cnt_wrap: got %h exp 0", pkt_cnt_out); end
        pkt_vld_in = 4'b0001;
        tick();
        pkt_vld_in = 4'b0000;
        tick();
        checks++; if (pkt_cnt_out !== 32'd1) begin errors++; $display("FAIL cnt_after_wrap: got %0d exp 1", pkt_cnt_out); end
        pkt_vld_in = 4'b0001;
        tick();
        pkt_vld_in = 4'b0000; cnt_clr_in = 1'b1;
        tick();
        cnt_clr_in = 1'b0;
        checks++; if (pkt_cnt_out !== 32'd0) begin errors++; $display("FAIL cnt_clr_priority: got %0d exp 0", pkt_cnt_out); end
    endtask

    task automatic test_reset_midstream();
        put(2, 32'hD2); pkt_vld_in = 4'b0100; pkt_rdy_in = 1'b0;
        #1;
        checks++; if (pkt_rdy_out !== 4'b0100) begin errors++; $display("FAIL mid_load_rdy: got %b exp 0100", pkt_rdy_out); end
        tick();
        put(0, 32'hD0); put(3, 32'hD3); pkt_vld_in = 4'b1001;
        #1;
        checks++; if (pkt_rdy_out !== 4'b0000 || pkt_vld_out !== 1'b1) begin errors++; $display("FAIL mid_held: got rdy %b vld %b exp 0000 1", pkt_rdy_out, pkt_vld_out); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (pkt_vld_out !== 1'b0 || pkt_rdy_out !== 4'b0000) begin errors++; $display("FAIL mid_async: got vld %b rdy %b exp 0 0000", pkt_vld_out, pkt_rdy_out); end
        tick();
        rst = 1'b0; pkt_rdy_in = 1'b1;
        #1;
        checks++; if (pkt_rdy_out !== 4'b0001) begin errors++; $display("FAIL mid_first_rdy: got %b exp 0001", pkt_rdy_out); end
        tick();
        checks++; if (pkt_src_out !== 2'd0 || pkt_data_out !== make_pkt(0, 32'hD0)) begin errors++; $display("FAIL mid_first_src: got %0d exp 0", pkt_src_out); end
        #1;
        checks++; if (pkt_rdy_out !== 4'b1000) begin errors++; $display("FAIL mid_second_rdy: got %b exp 1000", pkt_rdy_out); end
        tick();
        pkt_vld_in = 4'b0000;
        checks++; if (pkt_src_out !== 2'd3 || pkt_data_out !== make_pkt(3, 32'hD3)) begin errors++; $display("FAIL mid_second_src: got %0d exp 3", pkt_src_out); end
        tick();
        checks++; if (pkt_vld_out !== 1'b0 || pkt_cnt_out !== 32'd2) begin errors++; $display("FAIL mid_drain: got vld %b cnt %0d exp 0 2", pkt_vld_out, pkt_cnt_out); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        pkt_data_in = '0;
        test_reset();
        test_single_port();
        test_fairness();
        test_backpressure();
        test_enable_mask();
        test_counter_edges();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
